// File: rtl/rvfi_pkg.sv
// RVFI retire packet types shared by the core trace path and the commit serializer.
// rvfi_order_entry_t pairs a packet with its 64-bit retire order number.
package rvfi_pkg;

  typedef struct packed {
    logic        valid;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [31:0] insn;
    logic [63:0] pc_rdata;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
  } rvfi_instr_t;

  typedef struct packed {
    logic [63:0] order;
    rvfi_instr_t instr;
  } rvfi_order_entry_t;

  // A trapping instruction still retires and must be traced.
  function automatic logic is_live(input rvfi_instr_t p);
    return p.valid | p.trap;
  endfunction

endpackage

// File: rtl/rvfi_port_compactor.sv
// Combinational: packs live commit ports into ascending slots, tagging each with its
// order offset 0..n-1 within the cycle; zero latency, no flow control.
module rvfi_port_compactor
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input  rvfi_instr_t                          rvfi      [NR_COMMIT_PORTS],
  output rvfi_order_entry_t                    compacted [NR_COMMIT_PORTS],
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0] n_live
);

  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

  // Slot k receives the live port whose count of older live ports equals k.
  always_comb begin
    int rank;
    rank = 0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      compacted[k] = '0;
    end
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (is_live(rvfi[i])) begin
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
          if (k == rank) begin
            compacted[k] = '{order: 64'(k), instr: rvfi[i]};
          end
        end
        rank++;
      end
    end
    n_live = CW'(rank);
  end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Buffers up to NR_COMMIT_PORTS retires/cycle and replays them one per valid/ready handshake
// with a retire order tag; 1-cycle min latency; the core is never stalled, overflow drops and counts.
module rvfi_commit_serializer
  import rvfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  rvfi_instr_t              rvfi_i [NR_COMMIT_PORTS],
  output rvfi_instr_t              rvfi_o,
  output logic [63:0]              order_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o,
  output logic [31:0]              drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < NR_COMMIT_PORTS)) begin : g_param_check
    $error("rvfi_commit_serializer: DEPTH must be a power of two and >= NR_COMMIT_PORTS");
  end

  rvfi_order_entry_t mem [DEPTH];
  rvfi_order_entry_t compacted [NR_COMMIT_PORTS];
  rvfi_order_entry_t head;
  logic [CW-1:0]     n_live;
  logic [LW-1:0]     wptr, rptr, level;
  logic [LW-1:0]     wsum [NR_COMMIT_PORTS];
  logic [LW:0]       free, n_live_x, n_push, n_drop;
  logic [63:0]       order_cnt;
  logic [31:0]       drop_cnt;
  logic [32:0]       drop_sum;
  logic              overflow, empty, pop;

  rvfi_port_compactor #(
    .NR_COMMIT_PORTS(NR_COMMIT_PORTS)
  ) u_compactor (
    .rvfi      (rvfi_i),
    .compacted (compacted),
    .n_live    (n_live)
  );

  assign level    = wptr - rptr;
  assign empty    = (level == '0);
  assign pop      = !empty && ready_i && !clear_i;
  // A same-cycle pop hands its slot to this cycle's pushes.
  assign free     = (LW+1)'(DEPTH) - {1'b0, level} + {{LW{1'b0}}, pop};
  assign n_live_x = (LW+1)'(n_live);
  assign n_push   = clear_i ? '0 : ((n_live_x < free) ? n_live_x : free);
  assign n_drop   = clear_i ? '0 : (n_live_x - n_push);
  assign drop_sum = {1'b0, drop_cnt} + 33'(n_drop);

  always_comb begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      wsum[k] = wptr + LW'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if ((LW+1)'(k) < n_push) begin
        mem[wsum[k][AW-1:0]] <= '{order: order_cnt + compacted[k].order,
                                  instr: compacted[k].instr};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      order_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clear_i) begin
      wptr      <= '0;
      rptr      <= '0;
      order_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      wptr      <= wptr + n_push[LW-1:0];
      rptr      <= rptr + LW'(pop);
      // Dropped packets still consume order numbers so the consumer sees the gap.
      order_cnt <= order_cnt + 64'(n_live);
      drop_cnt  <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      overflow  <= overflow | (n_drop != '0);
    end
  end

  assign head       = mem[rptr[AW-1:0]];
  assign valid_o    = !empty;
  assign rvfi_o     = empty ? '0 : head.instr;
  assign order_o    = empty ? '0 : head.order;
  assign level_o    = level;
  assign overflow_o = overflow;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Bench for rvfi_commit_serializer: directed scenarios plus random traffic, every cycle
// checked against a queue-based model of the retire stream.
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;
  rvfi_instr_t rvfi [NR];
  rvfi_instr_t stim [NR];
  rvfi_instr_t rvfi_o;
  logic [63:0] order_o;
  logic        valid_o;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic [31:0] drop_cnt_o;

  rvfi_order_entry_t m_q [$];
  logic [63:0]       m_order;
  logic [31:0]       m_drops;
  logic              m_ovf;
  rvfi_instr_t       p0, p1;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  rvfi_commit_serializer #(
    .NR_COMMIT_PORTS(NR),
    .DEPTH          (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .rvfi_i     (rvfi),
    .rvfi_o     (rvfi_o),
    .order_o    (order_o),
    .valid_o    (valid_o),
    .ready_i    (ready),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rvfi_instr_t rand_pkt(input bit live);
    rvfi_instr_t p;
    p.intr     = 1'($urandom);
    p.mode     = 2'($urandom);
    p.insn     = $urandom;
    p.pc_rdata = {$urandom, $urandom};
    p.rd_addr  = 5'($urandom);
    p.rd_wdata = {$urandom, $urandom};
    p.valid    = 1'b0;
    p.trap     = 1'b0;
    if (live) begin
      case ($urandom_range(0, 2))
        0:       p.valid = 1'b1;
        1:       p.trap  = 1'b1;
        default: begin p.valid = 1'b1; p.trap = 1'b1; end
      endcase
    end
    return p;
  endfunction

  task automatic set_ports(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++) stim[i] = rand_pkt(mask[i]);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_order = '0;
    m_drops = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_all();
    rvfi_instr_t ep;
    logic [63:0] eo;
    ep = '0;
    eo = '0;
    if (m_q.size() != 0) begin
      ep = m_q[0].instr;
      eo = m_q[0].order;
    end
    chk("valid", 256'(valid_o), 256'(m_q.size() != 0));
    chk("rvfi", 256'(rvfi_o), 256'(ep));
    chk("order", 256'(order_o), 256'(eo));
    chk("level", 256'(level_o), 256'(m_q.size()));
    chk("overflow", 256'(overflow_o), 256'(m_ovf));
    chk("drop_cnt", 256'(drop_cnt_o), 256'(m_drops));
  endtask

  // Model: pop first (frees a slot), then append live ports oldest-first while room remains.
  task automatic step(input logic rdy, input logic clr);
    rvfi  = stim;
    ready = rdy;
    clear = clr;
    if (clr) begin
      model_reset();
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      for (int i = 0; i < NR; i++) begin
        if (stim[i].valid || stim[i].trap) begin
          if (m_q.size() < int'(DEPTH)) m_q.push_back('{order: m_order, instr: stim[i]});
          else begin
            if (m_drops != 32'hFFFF_FFFF) m_drops++;
            m_ovf = 1'b1;
          end
          m_order++;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    set_ports('0);
    rvfi = stim;
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Two live ports into an empty FIFO drain over the next two cycles.
    set_ports(2'b11);
    p0 = stim[0];
    p1 = stim[1];
    step(1'b1, 1'b0);
    chk("t1_order0", 256'(order_o), 256'(0));
    chk("t1_pkt0", 256'(rvfi_o), 256'(p0));
    set_ports('0);
    step(1'b1, 1'b0);
    chk("t1_order1", 256'(order_o), 256'(1));
    chk("t1_pkt1", 256'(rvfi_o), 256'(p1));
    step(1'b1, 1'b0);
    chk("t1_empty", 256'(valid_o), 256'(0));

    // Trap-only packet on port 1 with port 0 idle.
    set_ports(2'b11);
    step(1'b1, 1'b1);
    stim[0] = rand_pkt(1'b0);
    stim[1] = rand_pkt(1'b0);
    stim[1].trap = 1'b1;
    step(1'b1, 1'b0);
    chk("t2_order", 256'(order_o), 256'(0));
    chk("t2_trap", 256'(rvfi_o.trap), 256'(1));
    chk("t2_validfld", 256'(rvfi_o.valid), 256'(0));
    set_ports('0);
    step(1'b1, 1'b0);
    chk("t2_level", 256'(level_o), 256'(0));

    // Overflow with ready low, then drain and observe the order gap.
    step(1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      set_ports(2'b11);
      step(1'b0, 1'b0);
      if (c == 3) chk("t3_level_full", 256'(level_o), 256'(8));
    end
    chk("t3_drops", 256'(drop_cnt_o), 256'(2));
    chk("t3_ovf", 256'(overflow_o), 256'(1));
    chk("t3_head0", 256'(order_o), 256'(0));
    set_ports('0);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0);
    set_ports(2'b01);
    step(1'b1, 1'b0);
    chk("t3_gap_order", 256'(order_o), 256'(10));
    set_ports('0);
    step(1'b1, 1'b0);

    // Full FIFO with a pop: one of two new packets fits.
    for (int c = 0; c < 4; c++) begin
      set_ports(2'b11);
      step(1'b0, 1'b0);
    end
    set_ports(2'b11);
    step(1'b1, 1'b0);
    chk("t4_level", 256'(level_o), 256'(8));
    chk("t4_drops", 256'(drop_cnt_o), 256'(3));

    // Clear at level 5 with live ports discards everything.
    set_ports('0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
    chk("t5_level5", 256'(level_o), 256'(5));
    set_ports(2'b11);
    step(1'b1, 1'b1);
    chk("t5_level", 256'(level_o), 256'(0));
    chk("t5_valid", 256'(valid_o), 256'(0));
    chk("t5_ovf", 256'(overflow_o), 256'(0));
    chk("t5_drops", 256'(drop_cnt_o), 256'(0));
    set_ports(2'b10);
    step(1'b0, 1'b0);
    chk("t5_order", 256'(order_o), 256'(0));

    // Asynchronous reset mid-stream at level 3.
    set_ports(2'b11);
    step(1'b0, 1'b0);
    chk("t6_level3", 256'(level_o), 256'(3));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    set_ports('0);
    rvfi  = stim;
    ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_ports(2'b01);
    step(1'b1, 1'b0);
    chk("t6_order", 256'(order_o), 256'(0));
    chk("t6_valid", 256'(valid_o), 256'(1));

    // Random traffic alternating between drain-heavy and fill-heavy phases.
    for (int it = 0; it < 600; it++) begin
      logic rdy;
      set_ports(NR'($urandom_range(0, (1 << NR) - 1)));
      if (((it / 100) % 2) == 1) rdy = ($urandom_range(0, 3) == 0);
      else                       rdy = ($urandom_range(0, 3) != 0);
      step(rdy, ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
